// File: rtl/warp_scheduler_pkg.sv
// Shared pipeline-phase definitions for the warp scheduler, decoder and LSU.
// Every 3-bit encoding of warp_state_t is a named phase.
package warp_scheduler_pkg;

    localparam int NUM_WARPS_DEFAULT = 4;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

endpackage

// File: rtl/warp_scheduler_rr_picker.sv
// Combinational round-robin finder: first set bit after cur_idx, wrapping,
// with cur_idx itself as the lowest-priority candidate.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_mask,
    input  logic [W-1:0] cur_idx,
    output logic [W-1:0] next_idx,
    output logic         valid
);

    logic [W-1:0] idx;

    always_comb begin
        idx      = '0;
        next_idx = cur_idx;
        valid    = |req_mask;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int i = N; i >= 1; i--) begin
            idx = cur_idx + W'(i);
            if (req_mask[idx]) begin
                next_idx = idx;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Sequences the shared fetch/decode/execute pipeline through its phases,
// time-multiplexing it round-robin across the launched warps.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS     = NUM_WARPS_DEFAULT,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_WARPS-1:0]     warp_launch_mask,
    output logic                     fetch_req,
    input  logic                     fetch_ready,
    input  logic                     decoded_halt,
    input  logic                     decoded_mem_read_enable,
    input  logic                     decoded_mem_write_enable,
    input  logic                     lsu_done,
    output warp_state_t              warp_state,
    output logic [WARP_ID_WIDTH-1:0] current_warp,
    output logic                     pc_update_en,
    output logic [NUM_WARPS-1:0]     halted_mask,
    output logic                     done
);

    warp_state_t              state_q, state_d;
    logic [WARP_ID_WIDTH-1:0] cur_q, cur_d;
    logic [NUM_WARPS-1:0]     active_q, active_d;
    logic [NUM_WARPS-1:0]     halted_q, halted_d;
    logic                     done_q, done_d;

    logic                     idle_or_done;
    logic [NUM_WARPS-1:0]     pick_mask;
    logic [WARP_ID_WIDTH-1:0] pick_cur;
    logic [WARP_ID_WIDTH-1:0] pick_idx;
    logic                     pick_valid;

    assign idle_or_done = (state_q == WARP_IDLE) || (state_q == WARP_DONE);

    // At launch, searching after the top index yields the lowest set bit.
    assign pick_mask = idle_or_done ? warp_launch_mask : (active_q & ~halted_q);
    assign pick_cur  = idle_or_done ? '1 : cur_q;

    rr_picker #(
        .N (NUM_WARPS),
        .W (WARP_ID_WIDTH)
    ) u_rr_picker (
        .req_mask (pick_mask),
        .cur_idx  (pick_cur),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        active_d = active_q;
        halted_d = halted_q;
        done_d   = done_q;
        case (state_q)
            WARP_IDLE, WARP_DONE: begin
                if (start) begin
                    active_d = warp_launch_mask;
                    halted_d = '0;
                    done_d   = 1'b0;
                    if (pick_valid) begin
                        cur_d   = pick_idx;
                        state_d = WARP_FETCH;
                    end else begin
                        state_d = WARP_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            WARP_FETCH: begin
                if (fetch_ready) state_d = WARP_DECODE;
            end
            WARP_DECODE: state_d = WARP_REQUEST;
            WARP_REQUEST: begin
                if (decoded_halt) begin
                    halted_d[cur_q] = 1'b1;
                    state_d         = WARP_UPDATE;
                end else begin
                    state_d = WARP_WAIT;
                end
            end
            WARP_WAIT: begin
                if (!(decoded_mem_read_enable || decoded_mem_write_enable)
                    || lsu_done) begin
                    state_d = WARP_EXECUTE;
                end
            end
            WARP_EXECUTE: state_d = WARP_UPDATE;
            WARP_UPDATE: begin
                if (pick_valid) begin
                    cur_d   = pick_idx;
                    state_d = WARP_FETCH;
                end else begin
                    state_d = WARP_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = WARP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WARP_IDLE;
            cur_q    <= '0;
            active_q <= '0;
            halted_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            active_q <= active_d;
            halted_q <= halted_d;
            done_q   <= done_d;
        end
    end

    // A warp's halt bit is set in REQUEST, so in UPDATE it marks a halting instruction.
    assign pc_update_en = (state_q == WARP_UPDATE) && !halted_q[cur_q];
    assign fetch_req    = (state_q == WARP_FETCH);
    assign warp_state   = state_q;
    assign current_warp = cur_q;
    assign halted_mask  = halted_q;
    assign done         = done_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed self-checking bench for warp_scheduler with NUM_WARPS=4.
module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  warp_launch_mask;
    logic        fetch_req;
    logic        fetch_ready;
    logic        decoded_halt;
    logic        decoded_mem_read_enable;
    logic        decoded_mem_write_enable;
    logic        lsu_done;
    warp_state_t warp_state;
    logic [1:0]  current_warp;
    logic        pc_update_en;
    logic [3:0]  halted_mask;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    warp_scheduler #(.NUM_WARPS(4)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .warp_launch_mask         (warp_launch_mask),
        .fetch_req                (fetch_req),
        .fetch_ready              (fetch_ready),
        .decoded_halt             (decoded_halt),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .lsu_done                 (lsu_done),
        .warp_state               (warp_state),
        .current_warp             (current_warp),
        .pc_update_en             (pc_update_en),
        .halted_mask              (halted_mask),
        .done                     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting from an observed FETCH cycle.
    task automatic instr(input logic [1:0] cw, input bit halt,
                         input warp_state_t nst, input logic [1:0] ncw);
        check("fetch_state", warp_state, WARP_FETCH);
        check("fetch_warp", current_warp, cw);
        check("fetch_req_hi", fetch_req, 1'b1);
        decoded_halt             = halt;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        step();
        check("decode_state", warp_state, WARP_DECODE);
        check("fetch_req_lo", fetch_req, 1'b0);
        step();
        check("request_state", warp_state, WARP_REQUEST);
        if (!halt) begin
            step();
            check("wait_state", warp_state, WARP_WAIT);
            step();
            check("execute_state", warp_state, WARP_EXECUTE);
            check("execute_no_pc", pc_update_en, 1'b0);
        end
        step();
        check("update_state", warp_state, WARP_UPDATE);
        check("update_pc_en", pc_update_en, !halt);
        check("update_halt_bit", halted_mask[cw], halt);
        decoded_halt = 1'b0;
        step();
        check("next_state", warp_state, nst);
        check("next_warp", current_warp, ncw);
        check("next_no_pc", pc_update_en, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset                    = 1'b1;
        start                    = 1'b0;
        warp_launch_mask         = 4'b0000;
        fetch_ready              = 1'b0;
        decoded_halt             = 1'b0;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        lsu_done                 = 1'b0;
        step();
        step();
        check("rst_state", warp_state, WARP_IDLE);
        check("rst_warp", current_warp, 2'd0);
        check("rst_halted", halted_mask, 4'b0000);
        check("rst_pc_en", pc_update_en, 1'b0);
        check("rst_fetch_req", fetch_req, 1'b0);
        check("rst_done", done, 1'b0);

        // Two warps, round-robin 0,2,0,2 then warp 2 halts
        reset            = 1'b0;
        warp_launch_mask = 4'b0101;
        fetch_ready      = 1'b1;
        start            = 1'b1;
        step();
        start = 1'b0;
        instr(2'd0, 1'b0, WARP_FETCH, 2'd2);
        instr(2'd2, 1'b0, WARP_FETCH, 2'd0);
        instr(2'd0, 1'b0, WARP_FETCH, 2'd2);
        instr(2'd2, 1'b1, WARP_FETCH, 2'd0);
        check("halted_after_w2", halted_mask, 4'b0100);
        instr(2'd0, 1'b0, WARP_FETCH, 2'd0);
        instr(2'd0, 1'b1, WARP_DONE, 2'd0);
        check("done_all_halted", done, 1'b1);
        check("halted_all", halted_mask, 4'b0101);

        // Empty launch, then single warp 3
        warp_launch_mask = 4'b0000;
        start            = 1'b1;
        step();
        start = 1'b0;
        check("empty_state", warp_state, WARP_DONE);
        check("empty_done", done, 1'b1);
        check("empty_halted", halted_mask, 4'b0000);
        warp_launch_mask = 4'b1000;
        fetch_ready      = 1'b0;
        start            = 1'b1;
        step();
        start = 1'b0;
        check("w3_state", warp_state, WARP_FETCH);
        check("w3_warp", current_warp, 2'd3);
        check("w3_done_clr", done, 1'b0);
        check("w3_fetch_req1", fetch_req, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            step();
            check("stall_state", warp_state, WARP_FETCH);
            check("stall_fetch_req", fetch_req, 1'b1);
        end
        fetch_ready = 1'b1;
        step();
        check("stall_decode", warp_state, WARP_DECODE);

        // Load with lsu_done on the 7th WAIT cycle
        decoded_mem_read_enable = 1'b1;
        step();
        check("ld_request", warp_state, WARP_REQUEST);
        step();
        for (int i = 1; i <= 6; i++) begin
            check("ld_wait", warp_state, WARP_WAIT);
            step();
        end
        check("ld_wait7", warp_state, WARP_WAIT);
        lsu_done = 1'b1;
        step();
        check("ld_execute", warp_state, WARP_EXECUTE);
        warp_launch_mask = 4'b0001;
        start            = 1'b1;
        step();
        check("ld_update", warp_state, WARP_UPDATE);
        check("ld_update_warp", current_warp, 2'd3);
        check("ld_pc_en", pc_update_en, 1'b1);
        lsu_done                = 1'b0;
        start                   = 1'b0;
        decoded_mem_read_enable = 1'b0;
        step();
        check("self_resel_state", warp_state, WARP_FETCH);
        check("self_resel_warp", current_warp, 2'd3);

        // Reset while a store is outstanding in WAIT
        decoded_mem_write_enable = 1'b1;
        step();
        step();
        step();
        step();
        check("st_wait", warp_state, WARP_WAIT);
        reset = 1'b1;
        step();
        check("mid_rst_state", warp_state, WARP_IDLE);
        check("mid_rst_warp", current_warp, 2'd0);
        check("mid_rst_halted", halted_mask, 4'b0000);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_fetch_req", fetch_req, 1'b0);
        reset                    = 1'b0;
        decoded_mem_write_enable = 1'b0;
        step();
        check("post_rst_idle", warp_state, WARP_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
